active_window_tracker: RTL

Parametrised successor to the display-window qualifier. Takes raw horizontal/vertical counters from the video timing generator and produces registered active-area pixel coordinates, a data-enable, and line/frame boundary strobes. Adds a counter-continuity lock FSM, so downstream pixel generators only see valid coordinates from a verified, consistently sequencing raster. Sits between the timing generator and the pixel/framebuffer read logic.

---
 rtl/active_window_tracker.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/active_window_tracker.sv
// active_window_tracker
//   Qualifies raw raster counters from the video timing generator. It checks
//   that the counters step in order and locks onto the raster. Once locked, it
//   produces active-area pixel coordinates, a data-enable (ready) and
//   line/frame boundary strobes. Every output is registered, one clock after
//   the sample.
//
// Ports
//   clk          pixel clock
//   rst          synchronous reset, active-high
//   hcount       horizontal counter, 0..H_TOTAL-1
//   vcount       vertical counter, 0..V_TOTAL-1
//   posx, posy   active-area coordinates >> SCALE_SHIFT, 0 when not ready
//   ready        active pixel on a locked raster
//   line_start   first active pixel of an active line
//   line_end     last active pixel of an active line
//   frame_start  first active pixel of the frame
//   frame_end    last active pixel of the frame
//   locked       lock FSM is in LOCKED
//   sync_err     one-cycle pulse on a counter continuity violation
module active_window_tracker #(
  parameter int unsigned CNT_W       = 10,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_START     = 144,
  parameter int unsigned H_END       = 784,
  parameter int unsigned V_START     = 35,
  parameter int unsigned V_END       = 515,
  parameter int unsigned SCALE_SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] hcount,
  input  logic [CNT_W-1:0] vcount,
  output logic [CNT_W-1:0] posx,
  output logic [CNT_W-1:0] posy,
  output logic             ready,
  output logic             line_start,
  output logic             line_end,
  output logic             frame_start,
  output logic             frame_end,
  output logic             locked,
  output logic             sync_err
);

  // Raster constants at counter width. The range limits carry one extra bit so
  // that a period equal to 2**CNT_W still compares correctly.
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W:0]   H_LIMIT   = (CNT_W+1)'(H_TOTAL);
  localparam logic [CNT_W:0]   V_LIMIT   = (CNT_W+1)'(V_TOTAL);
  localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] H_END_C   = CNT_W'(H_END);
  localparam logic [CNT_W-1:0] H_FINAL_C = CNT_W'(H_END - 1);
  localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] V_END_C   = CNT_W'(V_END);
  localparam logic [CNT_W-1:0] V_FINAL_C = CNT_W'(V_END - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] prev_h_q, prev_v_q;

  logic [CNT_W-1:0] posx_q, posx_d;
  logic [CNT_W-1:0] posy_q, posy_d;
  logic             ready_q, ready_d;
  logic             line_start_q, line_start_d;
  logic             line_end_q, line_end_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_end_q, frame_end_d;
  logic             locked_q, locked_d;
  logic             sync_err_q, sync_err_d;

  logic [CNT_W-1:0] exp_h_c, exp_v_c;
  logic             out_of_range_c;
  logic             mismatch_c;
  logic             in_win_c;
  logic             at_origin_c;
  logic             at_last_c;
  logic             qual_c;
  logic [CNT_W-1:0] hoff_c, voff_c;

  // Predict the sample that should follow the previous one.
  always_comb begin
    exp_h_c = '0;
    exp_v_c = prev_v_q;
    if (prev_h_q < H_LAST) begin
      exp_h_c = prev_h_q + CNT_W'(1);
    end else if (prev_v_q < V_LAST) begin
      exp_v_c = prev_v_q + CNT_W'(1);
    end else begin
      exp_v_c = '0;
    end
  end

  // Continuity check. Out-of-range counters always count as a mismatch.
  always_comb begin
    out_of_range_c = ({1'b0, hcount} >= H_LIMIT) || ({1'b0, vcount} >= V_LIMIT);
    mismatch_c     = out_of_range_c || (hcount != exp_h_c) || (vcount != exp_v_c);
    at_origin_c    = (hcount == '0) && (vcount == '0);
    at_last_c      = (hcount == H_LAST) && (vcount == V_LAST);
  end

  // The active window is half-open on both axes.
  always_comb begin
    in_win_c = (hcount >= H_START_C) && (hcount < H_END_C) &&
               (vcount >= V_START_C) && (vcount < V_END_C);
  end

  // Lock FSM: next state and the error pulse.
  always_comb begin
    state_d    = state_q;
    sync_err_d = 1'b0;
    unique case (state_q)
      ST_SEARCH: begin
        if (at_origin_c) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (mismatch_c) begin
          state_d    = ST_SEARCH;
          sync_err_d = 1'b1;
        end else if (at_last_c) begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (mismatch_c) begin
          state_d    = ST_SEARCH;
          sync_err_d = 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
    locked_d = (state_d == ST_LOCKED);
  end

  // Qualified outputs. They are computed only from the current sample, so a
  // glitch never leaves residue in the coordinates.
  always_comb begin
    qual_c        = (state_q == ST_LOCKED) && !mismatch_c && in_win_c;
    hoff_c        = hcount - H_START_C;
    voff_c        = vcount - V_START_C;
    posx_d        = '0;
    posy_d        = '0;
    ready_d       = qual_c;
    line_start_d  = qual_c && (hcount == H_START_C);
    line_end_d    = qual_c && (hcount == H_FINAL_C);
    frame_start_d = line_start_d && (vcount == V_START_C);
    frame_end_d   = line_end_d && (vcount == V_FINAL_C);
    if (qual_c) begin
      posx_d = hoff_c >> SCALE_SHIFT;
      posy_d = voff_c >> SCALE_SHIFT;
    end
  end

  // State, previous sample and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_SEARCH;
      prev_h_q      <= '0;
      prev_v_q      <= '0;
      posx_q        <= '0;
      posy_q        <= '0;
      ready_q       <= 1'b0;
      line_start_q  <= 1'b0;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_h_q      <= hcount;
      prev_v_q      <= vcount;
      posx_q        <= posx_d;
      posy_q        <= posy_d;
      ready_q       <= ready_d;
      line_start_q  <= line_start_d;
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign posx        = posx_q;
  assign posy        = posy_q;
  assign ready       = ready_q;
  assign line_start  = line_start_q;
  assign line_end    = line_end_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;

endmodule
